// File: rtl/axis_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order through two ping-pong frame banks.
// Latency: first output one clock after a frame's last input; m_* holds while stalled, s_tready drops when both banks are full.
module axis_bitrev_reorder #(
    parameter int LOG2N = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata_re,
    input  logic [DW-1:0] s_tdata_im,
    input  logic          s_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata_re,
    output logic [DW-1:0] m_tdata_im,
    output logic          m_tlast,
    output logic          err_tlast
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [2*DW-1:0]  mem [2*N];
    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] rd_rev;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_hs;
    logic             wr_end;
    logic             load;
    logic             rd_end;
    logic [2*DW-1:0]  rd_word;

    assign s_tready = !full[wr_bank];
    assign wr_hs    = s_tvalid && s_tready;
    assign wr_end   = wr_hs && (wr_cnt == LAST);
    assign load     = full[rd_bank] && (!m_tvalid || m_tready);
    assign rd_end   = load && (rd_cnt == LAST);

    always_comb begin
        rd_rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            rd_rev[i] = rd_cnt[LOG2N-1-i];
        end
    end

    // Set and clear always hit different banks, so both can apply in one cycle.
    always_comb begin
        full_nxt = full;
        if (wr_end) full_nxt[wr_bank] = 1'b1;
        if (rd_end) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem[{wr_bank, wr_cnt}] <= {s_tdata_re, s_tdata_im};
        end
    end

    assign rd_word = mem[{rd_bank, rd_rev}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            full      <= '0;
            err_tlast <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_hs) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (s_tlast != (wr_cnt == LAST)) err_tlast <= 1'b1;
                if (wr_end) wr_bank <= !wr_bank;
            end
            if (load) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_end) rd_bank <= !rd_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata_re <= '0;
            m_tdata_im <= '0;
        end else if (load) begin
            m_tvalid   <= 1'b1;
            m_tlast    <= (rd_cnt == LAST);
            m_tdata_re <= rd_word[2*DW-1:DW];
            m_tdata_im <= rd_word[DW-1:0];
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_bitrev_reorder.sv
// Bench for axis_bitrev_reorder: directed table plus streaming sequences against a frame scoreboard.
module tb_axis_bitrev_reorder;
    localparam int LOG2N = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata_re = '0;
    logic [DW-1:0] s_tdata_im = '0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata_re;
    logic [DW-1:0] m_tdata_im;
    logic          m_tlast;
    logic          err_tlast;

    axis_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata_re(s_tdata_re), .s_tdata_im(s_tdata_im), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata_re(m_tdata_re), .m_tdata_im(m_tdata_im), .m_tlast(m_tlast),
        .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in_re;
        logic [31:0] in_im;
        logic [31:0] exp_re;
        logic [31:0] exp_im;
        logic        exp_last;
    } vec_t;
    vec_t tbl[16];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rdy_pct = 100;
    int          seq = 1;
    int          wpos = 0;
    int          out_cnt = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          stalls = 0;
    logic        exp_err = 1'b0;
    bit          held = 1'b0;
    bit          capture = 1'b0;
    logic [64:0] held_v;
    logic [64:0] act;
    logic [64:0] e;
    logic [63:0] frame_buf[16];
    logic [64:0] expq[$];
    logic [64:0] cap[$];

    function automatic logic [3:0] br4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [64:0] a, input logic [64:0] b);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, a, b, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = ($urandom_range(0, 99) < rdy_pct);
    end

    // Scoreboard: inputs and outputs are both observed at the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (!rst) begin
            chk(err_tlast === exp_err, "err_tlast", 65'(err_tlast), 65'(exp_err));
            act = {m_tlast, m_tdata_re, m_tdata_im};
            if (held) chk(m_tvalid && act === held_v, "stall_stable", act, held_v);
            held   = m_tvalid && !m_tready;
            held_v = act;
            if (m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    chk(1'b0, "unexpected_out", act, 65'(0));
                end else begin
                    e = expq.pop_front();
                    chk(act === e, "out_data", act, e);
                end
                if (capture) cap.push_back(act);
                if (out_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                out_cnt++;
            end
            if (s_tvalid && s_tready) begin
                if (s_tlast != (wpos == 15)) exp_err = 1'b1;
                frame_buf[wpos] = {s_tdata_re, s_tdata_im};
                if (wpos == 15) begin
                    for (int j = 0; j < 16; j++) expq.push_back({j == 15, frame_buf[br4(4'(j))]});
                end
                wpos = (wpos + 1) % 16;
            end
        end
    end

    task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last, input int pv);
        int  g;
        bit  hs;
        g  = 0;
        hs = 1'b0;
        s_tdata_re = re;
        s_tdata_im = im;
        s_tlast    = last;
        while (!hs && g < 3000) begin
            s_tvalid = ($urandom_range(0, 99) < pv);
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!hs) chk(1'b0, "send_timeout", 65'(g), 65'(0));
        stalls += g - 1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int pv, input int err_idx);
        for (int p = 0; p < 16; p++) begin
            send(32'(seq), 32'(seq * 7) ^ 32'hC3C3_0000, (err_idx >= 0) ? (p == err_idx) : (p == 15), pv);
            seq++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((expq.size() != 0 || m_tvalid) && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk(g < 3000, "drain_timeout", 65'(expq.size()), 65'(0));
    endtask

    task automatic pulse_rst();
        #1;
        rst = 1'b1;
        #1;
        chk(m_tvalid === 1'b0, "rst_m_tvalid", 65'(m_tvalid), 65'(0));
        chk({m_tlast, m_tdata_re, m_tdata_im} === 65'(0), "rst_m_data", {m_tlast, m_tdata_re, m_tdata_im}, 65'(0));
        chk(err_tlast === 1'b0, "rst_err", 65'(err_tlast), 65'(0));
        chk(s_tready === 1'b1, "rst_s_tready", 65'(s_tready), 65'(1));
        #1;
        rst = 1'b0;
        expq.delete();
        wpos    = 0;
        exp_err = 1'b0;
        held    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   brt[16];
        int   acc;
        bit   hs;
        brt = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int k = 0; k < 16; k++) begin
            tbl[k].in_re    = 32'(brt[k]);
            tbl[k].in_im    = ~32'(brt[k]);
            tbl[k].exp_re   = 32'(k);
            tbl[k].exp_im   = ~32'(k);
            tbl[k].exp_last = (k == 15);
        end

        #2;
        chk(m_tvalid === 1'b0, "reset_m_tvalid", 65'(m_tvalid), 65'(0));
        chk({m_tlast, m_tdata_re, m_tdata_im} === 65'(0), "reset_m_data", {m_tlast, m_tdata_re, m_tdata_im}, 65'(0));
        chk(err_tlast === 1'b0, "reset_err", 65'(err_tlast), 65'(0));
        chk(s_tready === 1'b1, "reset_s_tready", 65'(s_tready), 65'(1));
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame from the hand-computed table, plus first-output latency.
        capture = 1'b1;
        for (int k = 0; k < 16; k++) send(tbl[k].in_re, tbl[k].in_im, k == 15, 100);
        @(negedge clk);
        chk(m_tvalid === 1'b0, "latency_edge_e", 65'(m_tvalid), 65'(0));
        @(negedge clk);
        chk(m_tvalid === 1'b1 && m_tdata_re === 32'd0, "latency_edge_e1", {m_tvalid, m_tdata_re}, {1'b1, 32'd0});
        drain();
        capture = 1'b0;
        chk(cap.size() == 16, "table_out_count", 65'(cap.size()), 65'(16));
        for (int k = 0; k < 16; k++) begin
            chk(cap[k] === {tbl[k].exp_last, tbl[k].exp_re, tbl[k].exp_im}, "table_out", cap[k],
                {tbl[k].exp_last, tbl[k].exp_re, tbl[k].exp_im});
        end
        chk(err_tlast === 1'b0, "table_err", 65'(err_tlast), 65'(0));

        // Four back-to-back frames, both sides always ready.
        out_cnt = 0;
        stalls  = 0;
        repeat (4) send_frame(100, -1);
        drain();
        chk(stalls == 0, "b2b_stalls", 65'(stalls), 65'(0));
        chk(out_cnt == 64, "b2b_out_count", 65'(out_cnt), 65'(64));
        chk(last_cyc - first_cyc == 63, "b2b_no_bubbles", 65'(last_cyc - first_cyc), 65'(63));

        // Downstream blocked for 40 cycles: exactly two frames are accepted.
        rdy_pct = 0;
        @(posedge clk);
        #1;
        out_cnt = 0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            s_tvalid   = 1'b1;
            s_tdata_re = 32'(seq);
            s_tdata_im = ~32'(seq);
            s_tlast    = ((acc % 16) == 15);
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc++;
                seq++;
            end
        end
        s_tvalid = 1'b0;
        chk(acc == 32, "blocked_accept_count", 65'(acc), 65'(32));
        chk(s_tready === 1'b0, "blocked_s_tready", 65'(s_tready), 65'(0));
        chk(out_cnt == 0, "blocked_no_output", 65'(out_cnt), 65'(0));
        rdy_pct = 100;
        drain();
        chk(out_cnt == 32, "blocked_drain_count", 65'(out_cnt), 65'(32));

        // Random valid / ready over 20 frames.
        rdy_pct = 30;
        out_cnt = 0;
        repeat (20) send_frame(50, -1);
        drain();
        chk(out_cnt == 320, "random_out_count", 65'(out_cnt), 65'(320));
        rdy_pct = 100;

        // Misplaced tlast: flagged, frame size unchanged, flag sticky.
        send_frame(100, 7);
        drain();
        chk(err_tlast === 1'b1, "tlast_err_set", 65'(err_tlast), 65'(1));
        send_frame(100, -1);
        drain();
        chk(err_tlast === 1'b1, "tlast_err_sticky", 65'(err_tlast), 65'(1));

        // Reset pulsed between edges with a frame pending and a partial frame in flight.
        rdy_pct = 0;
        @(posedge clk);
        #1;
        send_frame(100, -1);
        for (int i = 0; i < 9; i++) begin
            send(32'(seq), 32'(seq), 1'b0, 100);
            seq++;
        end
        @(negedge clk);
        chk(m_tvalid === 1'b1, "pre_rst_m_tvalid", 65'(m_tvalid), 65'(1));
        @(posedge clk);
        pulse_rst();
        rdy_pct = 100;
        out_cnt = 0;
        @(posedge clk);
        #1;
        send_frame(100, -1);
        drain();
        chk(out_cnt == 16, "post_rst_out_count", 65'(out_cnt), 65'(16));
        chk(err_tlast === 1'b0, "post_rst_err", 65'(err_tlast), 65'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
